vram_arbiter: RTL and testbench

Shares the single-port synchronous video RAM between the display scanout fetcher and the CPU bus. The fetcher is paced by the sync_gen timing. Display fetches have absolute priority, because a missed fetch corrupts the picture. The CPU is served in any cycle with no display fetch, through a req/ack handshake. A saturating stall counter records CPU starvation so firmware can check that its blanking-time budget holds.

---
 rtl/vram_arbiter.sv | 138 +++++++++++++
 tb/tb_vram_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port synchronous VRAM between the display
// scanout fetcher (absolute priority) and the CPU bus (req/ack handshake).
// Two-edge fixed latency: grant/register at E0, VRAM samples at E1,
// read data captured and valid/ack pulsed at E2. Each grant carries an owner
// tag down a short valid pipeline so responses are routed correctly.
module vram_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int STALL_W = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               on_screen,
    input  logic               disp_req,
    input  logic [ADDR_W-1:0]  disp_addr,
    output logic [DATA_W-1:0]  disp_data,
    output logic               disp_valid,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [ADDR_W-1:0]  cpu_addr,
    input  logic [DATA_W-1:0]  cpu_wdata,
    output logic               cpu_ack,
    output logic [DATA_W-1:0]  cpu_rdata,
    output logic               mem_en,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata,
    output logic [STALL_W-1:0] stall_count,
    input  logic               stall_clr
);

    // Owner tag carried alongside each access through the pipeline.
    typedef struct packed {
        logic vld;
        logic cpu;
        logic we;
    } tag_t;

    // Stage 0 is the access issued to VRAM, stage STAGES is the one whose
    // read data is on mem_rdata this cycle.
    localparam int STAGES = 1;

    tag_t [STAGES:0] vld_pipe;
    tag_t            a_tag;
    logic            cpu_busy;
    logic            grant_disp;
    logic            grant_cpu;
    logic            stall_inc;
    logic            resp_disp;
    logic            resp_cpu;

    // Grant decision: display always wins; CPU only when idle and not in flight.
    always_comb begin
        grant_disp = disp_req;
        grant_cpu  = !disp_req && cpu_req && !cpu_busy;
        stall_inc  = disp_req && cpu_req && !cpu_busy && on_screen;
        a_tag.vld  = grant_disp || grant_cpu;
        a_tag.cpu  = grant_cpu;
        a_tag.we   = grant_cpu && cpu_we;
        resp_disp  = vld_pipe[STAGES].vld && !vld_pipe[STAGES].cpu;
        resp_cpu   = vld_pipe[STAGES].vld && vld_pipe[STAGES].cpu;
    end

    // Stage A: register the VRAM command; address/data hold when idle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_en <= grant_disp || grant_cpu;
            mem_we <= grant_cpu && cpu_we;
            if (grant_disp) begin
                mem_addr <= disp_addr;
            end else if (grant_cpu) begin
                mem_addr  <= cpu_addr;
                mem_wdata <= cpu_wdata;
            end
        end
    end

    // Owner tag shift register; reset drops anything in flight.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= a_tag;
            for (int i = 1; i <= STAGES; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
            end
        end
    end

    // CPU in-flight flag: set on grant, cleared on the edge that drives the ack.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cpu_busy <= 1'b0;
        end else if (grant_cpu) begin
            cpu_busy <= 1'b1;
        end else if (resp_cpu) begin
            cpu_busy <= 1'b0;
        end
    end

    // Stage B: capture read data and pulse the owner's valid/ack.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            disp_valid <= 1'b0;
            disp_data  <= '0;
            cpu_ack    <= 1'b0;
            cpu_rdata  <= '0;
        end else begin
            disp_valid <= resp_disp;
            cpu_ack    <= resp_cpu;
            if (resp_disp) begin
                disp_data <= mem_rdata;
            end
            // Writes ack without disturbing the last read value.
            if (resp_cpu && !vld_pipe[STAGES].we) begin
                cpu_rdata <= mem_rdata;
            end
        end
    end

    // Saturating count of visible-region CPU stalls; clear beats increment.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_count <= '0;
        end else if (stall_clr) begin
            stall_count <= '0;
        end else if (stall_inc && (stall_count != '1)) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios followed by a randomized run
// checked against a transaction-level reference (in-order memory image,
// latency slots, saturating stall counter).
module tb_vram_arbiter;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int SW = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          on_screen = 1'b0;
    logic          disp_req = 1'b0;
    logic [AW-1:0] disp_addr = '0;
    logic [DW-1:0] disp_data;
    logic          disp_valid;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic [SW-1:0] stall_count;
    logic          stall_clr = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STALL_W(SW)) dut (
        .CLK(CLK), .RST(RST), .on_screen(on_screen),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(disp_data), .disp_valid(disp_valid),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall_count(stall_count), .stall_clr(stall_clr)
    );

    always #5 CLK = ~CLK;

    // Single-port synchronous VRAM: read data valid the cycle after sampling.
    logic [DW-1:0] vram [0:65535];
    always @(posedge CLK) begin
        if (mem_en) begin
            if (mem_we) vram[mem_addr] <= mem_wdata;
            else        mem_rdata      <= vram[mem_addr];
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " mem_en"},      32'(mem_en),      0);
        chk({tag, " mem_we"},      32'(mem_we),      0);
        chk({tag, " mem_addr"},    32'(mem_addr),    0);
        chk({tag, " mem_wdata"},   32'(mem_wdata),   0);
        chk({tag, " disp_valid"},  32'(disp_valid),  0);
        chk({tag, " disp_data"},   32'(disp_data),   0);
        chk({tag, " cpu_ack"},     32'(cpu_ack),     0);
        chk({tag, " cpu_rdata"},   32'(cpu_rdata),   0);
        chk({tag, " stall_count"}, 32'(stall_count), 0);
    endtask

    // CPU read of 0x0200 held while the display takes four consecutive edges.
    task automatic contention(input logic vis, input logic [SW-1:0] exp_stall);
        stall_clr = 1'b1;
        tick();
        stall_clr = 1'b0;
        chk("cont clr", 32'(stall_count), 0);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0200; on_screen = vis;
        for (int i = 0; i < 4; i++) begin
            disp_req = 1'b1; disp_addr = 16'(16'h0040 + i);
            tick();
            chk("cont disp addr", 32'(mem_addr), 32'(16'h0040 + i));
            chk("cont disp we",   32'(mem_we),   0);
        end
        disp_req = 1'b0;
        tick();
        chk("cont cpu grant addr", 32'(mem_addr), 32'h0200);
        chk("cont cpu grant en",   32'(mem_en),   1);
        tick();
        chk("cont ack early", 32'(cpu_ack), 0);
        tick();
        chk("cont ack",       32'(cpu_ack),    1);
        chk("cont no dv",     32'(disp_valid), 0);
        chk("cont rdata",     32'(cpu_rdata),  32'h1234);
        chk("cont stall",     32'(stall_count), 32'(exp_stall));
        cpu_req = 1'b0; on_screen = 1'b0;
        tick();
    endtask

    // Reference model state for the randomized phase.
    logic [DW-1:0] ref_mem [0:15];
    logic          exp_dv  [0:3];
    logic          exp_ack [0:3];
    logic [DW-1:0] exp_dd  [0:3];
    logic [DW-1:0] exp_cd  [0:3];

    initial begin
        int            busy_until;
        int            st;
        int            slot;
        int            cur;
        logic          busy, g_cpu, exp_en, exp_we;
        logic [DW-1:0] model_crd;

        // Reset state
        #1;
        chk_all_zero("reset");
        tick(); tick();
        @(negedge CLK) RST = 1'b0;
        tick();
        chk_all_zero("idle after reset");

        // Display read
        vram[16'h0010] = 16'hBEEF;
        disp_req = 1'b1; disp_addr = 16'h0010;
        tick();
        disp_req = 1'b0;
        chk("disp E0 en",   32'(mem_en),     1);
        chk("disp E0 we",   32'(mem_we),     0);
        chk("disp E0 addr", 32'(mem_addr),   32'h0010);
        chk("disp E0 dv",   32'(disp_valid), 0);
        tick();
        chk("disp E1 dv",   32'(disp_valid), 0);
        chk("disp E1 en",   32'(mem_en),     0);
        tick();
        chk("disp E2 dv",   32'(disp_valid), 1);
        chk("disp E2 data", 32'(disp_data),  32'hBEEF);
        chk("disp E2 ack",  32'(cpu_ack),    0);
        tick();
        chk("disp E3 dv",   32'(disp_valid), 0);

        // CPU write then read
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0200; cpu_wdata = 16'h1234;
        tick();
        chk("wr E0 we",    32'(mem_we),    1);
        chk("wr E0 addr",  32'(mem_addr),  32'h0200);
        chk("wr E0 wdata", 32'(mem_wdata), 32'h1234);
        tick();
        chk("wr E1 we",    32'(mem_we),    0);
        chk("wr E1 ack",   32'(cpu_ack),   0);
        tick();
        chk("wr E2 ack",   32'(cpu_ack),   1);
        chk("wr rdata",    32'(cpu_rdata), 0);
        chk("wr E2 we",    32'(mem_we),    0);
        cpu_req = 1'b0;
        tick();
        chk("wr ack once", 32'(cpu_ack), 0);
        chk("wr vram",     32'(vram[16'h0200]), 32'h1234);
        cpu_req = 1'b1; cpu_we = 1'b0;
        tick();
        chk("rd E0 en", 32'(mem_en), 1);
        chk("rd E0 we", 32'(mem_we), 0);
        tick(); tick();
        chk("rd ack",   32'(cpu_ack),   1);
        chk("rd data",  32'(cpu_rdata), 32'h1234);
        cpu_req = 1'b0;
        tick();

        // Contention, visible and blanking
        contention(1'b1, 4'd4);
        contention(1'b0, 4'd0);

        // Saturation and clear priority
        on_screen = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
        disp_req = 1'b1; disp_addr = 16'h0000;
        repeat (20) tick();
        chk("sat value", 32'(stall_count), 32'hF);
        stall_clr = 1'b1;
        tick();
        stall_clr = 1'b0;
        chk("sat clr", 32'(stall_count), 0);
        disp_req = 1'b0;
        tick();
        chk("sat cpu grant", 32'(mem_addr), 32'h0010);
        tick(); tick();
        chk("sat ack",   32'(cpu_ack),     1);
        chk("sat rdata", 32'(cpu_rdata),   32'hBEEF);
        chk("sat hold0", 32'(stall_count), 0);
        cpu_req = 1'b0; on_screen = 1'b0;
        tick(); tick(); tick();

        // Asynchronous reset one cycle after a CPU grant
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0300; cpu_wdata = 16'h5555;
        tick();
        chk("rst grant we", 32'(mem_we), 1);
        tick();
        #1 RST = 1'b1;
        #1;
        chk_all_zero("async reset");
        tick();
        chk("rst held ack", 32'(cpu_ack), 0);
        @(negedge CLK) RST = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("rst reissue ack", 32'(cpu_ack), (i == 3) ? 1 : 0);
            if (i == 3) cpu_req = 1'b0;
        end
        chk("rst reissue vram", 32'(vram[16'h0300]), 32'h5555);

        // Randomized run against the transaction-level reference
        for (int a = 0; a < 16; a++) begin
            ref_mem[a] = 16'($urandom);
            vram[a]    = ref_mem[a];
        end
        for (int s = 0; s < 4; s++) begin
            exp_dv[s] = 1'b0; exp_ack[s] = 1'b0; exp_dd[s] = '0; exp_cd[s] = '0;
        end
        stall_clr = 1'b1;
        tick();
        stall_clr = 1'b0;
        st = 0; busy_until = -1; model_crd = '0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            disp_req  = ($urandom_range(0, 2) == 0);
            disp_addr = 16'($urandom_range(0, 15));
            on_screen = 1'($urandom_range(0, 1));
            stall_clr = ($urandom_range(0, 31) == 0);
            if (!cpu_req && ($urandom_range(0, 1) == 1)) begin
                cpu_req   = 1'b1;
                cpu_we    = 1'($urandom_range(0, 1));
                cpu_addr  = 16'($urandom_range(0, 15));
                cpu_wdata = 16'($urandom);
            end
            // Accesses reach memory in grant order, so each sees all earlier writes.
            busy  = (cyc <= busy_until);
            g_cpu = !disp_req && cpu_req && !busy;
            slot  = (cyc + 2) % 4;
            exp_dv[slot]  = disp_req;
            exp_ack[slot] = g_cpu;
            if (disp_req) exp_dd[slot] = ref_mem[disp_addr[3:0]];
            if (g_cpu) begin
                if (cpu_we) ref_mem[cpu_addr[3:0]] = cpu_wdata;
                else        model_crd = ref_mem[cpu_addr[3:0]];
                exp_cd[slot] = model_crd;
                busy_until   = cyc + 2;
            end
            exp_en = disp_req || g_cpu;
            exp_we = g_cpu && cpu_we;
            if (stall_clr) st = 0;
            else if (disp_req && cpu_req && !busy && on_screen && st < 15) st++;
            tick();
            cur = cyc % 4;
            chk("rnd mem_en",  32'(mem_en),     32'(exp_en));
            chk("rnd mem_we",  32'(mem_we),     32'(exp_we));
            chk("rnd dv",      32'(disp_valid), 32'(exp_dv[cur]));
            chk("rnd ack",     32'(cpu_ack),    32'(exp_ack[cur]));
            if (exp_dv[cur])  chk("rnd disp_data", 32'(disp_data), 32'(exp_dd[cur]));
            if (exp_ack[cur]) chk("rnd cpu_rdata", 32'(cpu_rdata), 32'(exp_cd[cur]));
            chk("rnd stall",   32'(stall_count), 32'(st));
            if (cpu_ack) cpu_req = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
